// File: rtl/pulse_sync_f2s.sv
// rtl/pulse_sync_f2s.sv - multi-channel fast-to-slow toggle-handshake pulse synchroniser (optional PULSE_SYNC_PENDING_EN)
module pulse_sync_f2s #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  clk1,
    input  logic                  clk2,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   pulse_in,
    input  logic                  drop_clr,
    output logic [CHANNELS-1:0]   busy,
    output logic [CHANNELS-1:0]   drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [CHANNELS-1:0]   pulse_out
);

    // Six extra bits hold the popcount of up to 32 simultaneous drops.
    localparam int SUM_W = DROP_CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = {{6{1'b0}}, {DROP_CNT_W{1'b1}}};

    logic [CHANNELS-1:0] req_tgl;
    logic [CHANNELS-1:0] req_next;
    logic [CHANNELS-1:0] drop;
    logic [CHANNELS-1:0] ack_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] req_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] dst_tgl;
    logic [5:0]          drop_pop;
    logic [SUM_W-1:0]    cnt_sum;

`ifdef PULSE_SYNC_PENDING_EN
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] pend_next;
    logic [CHANNELS-1:0] fall;
`endif

    // A channel is in flight while its request toggle differs from the returned acknowledge.
    assign busy = req_tgl ^ ack_sync[SYNC_STAGES-1];

    // Per-channel accept/drop decision and next request toggle.
    always_comb begin
        req_next = req_tgl;
        drop     = '0;
`ifdef PULSE_SYNC_PENDING_EN
        pend_next = pend;
        fall      = '0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PULSE_SYNC_PENDING_EN
            // busy is about to drop when the acknowledge entering the last stage matches req_tgl
            fall[i] = busy[i] & (req_tgl[i] == ack_sync[SYNC_STAGES-2][i]);
`endif
            if (!busy[i]) begin
                if (pulse_in[i]) begin
                    req_next[i] = ~req_tgl[i];
                end
            end
`ifdef PULSE_SYNC_PENDING_EN
            else if (pend[i]) begin
                drop[i] = pulse_in[i];
                if (fall[i]) begin
                    req_next[i]  = ~req_tgl[i];
                    pend_next[i] = 1'b0;
                end
            end else if (pulse_in[i]) begin
                // an event landing on the closing cycle is launched directly
                if (fall[i]) begin
                    req_next[i] = ~req_tgl[i];
                end else begin
                    pend_next[i] = 1'b1;
                end
            end
`else
            else begin
                drop[i] = pulse_in[i];
            end
`endif
        end
    end

    // Popcount of this cycle's drops and the saturating sum.
    always_comb begin
        drop_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            drop_pop = drop_pop + {5'd0, drop[i]};
        end
        cnt_sum = {6'd0, drop_cnt} + {{(SUM_W-6){1'b0}}, drop_pop};
        if (cnt_sum > CNT_MAX) begin
            cnt_sum = CNT_MAX;
        end
    end

    // Source-domain state: request toggles, acknowledge synchroniser, drop reporting.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            req_tgl    <= '0;
            drop_pulse <= '0;
            drop_cnt   <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                ack_sync[s] <= '0;
            end
        end else begin
            req_tgl     <= req_next;
            drop_pulse  <= drop;
            drop_cnt    <= drop_clr ? '0 : cnt_sum[DROP_CNT_W-1:0];
            ack_sync[0] <= dst_tgl;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                ack_sync[s] <= ack_sync[s-1];
            end
        end
    end

`ifdef PULSE_SYNC_PENDING_EN
    // One-deep pending slot per channel.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end
`endif

    // Destination-domain state: request synchroniser, toggle follower and edge pulse.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            dst_tgl   <= '0;
            pulse_out <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                req_sync[s] <= '0;
            end
        end else begin
            req_sync[0] <= req_tgl;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                req_sync[s] <= req_sync[s-1];
            end
            dst_tgl   <= req_sync[SYNC_STAGES-1];
            pulse_out <= req_sync[SYNC_STAGES-1] ^ dst_tgl;
        end
    end

endmodule

// File: tb/tb_pulse_sync_f2s.sv
// tb/tb_pulse_sync_f2s.sv - self-checking bench for pulse_sync_f2s
`timescale 1ns/1ps
module tb_pulse_sync_f2s;

`ifdef PULSE_SYNC_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       clk2 = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pulse_in = '0;
    logic       drop_clr = 1'b0;
    logic [3:0] busy;
    logic [3:0] drop_pulse;
    logic [2:0] drop_cnt;
    logic [3:0] pulse_out;

    realtime h1 = 5.0;
    realtime h2 = 10.0;

    int checks = 0;
    int passes = 0;
    int deliv[4];
    int exp_deliv[4];
    int dpc[4];
    int drops_total = 0;

    pulse_sync_f2s #(.CHANNELS(4), .SYNC_STAGES(2), .DROP_CNT_W(3)) dut (
        .clk1(clk1), .clk2(clk2), .reset(reset), .pulse_in(pulse_in), .drop_clr(drop_clr),
        .busy(busy), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .pulse_out(pulse_out)
    );

    initial forever #(h1) clk1 = ~clk1;
    initial begin
        #1;
        forever #(h2) clk2 = ~clk2;
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        else passes++;
    endtask

    function automatic int pc(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_idle();
        int idle = 0;
        int n = 0;
        while (idle < 20 && n < 600) begin
            @(negedge clk1);
            n++;
            if (busy == 4'd0) idle++;
            else idle = 0;
        end
        chk("idle_timeout", idle >= 20, 1);
    endtask

    function automatic int sum_deliv();
        return deliv[0] + deliv[1] + deliv[2] + deliv[3];
    endfunction

    // Clock-1 model: drop rule, saturating counter and expected delivery count, every cycle.
    initial begin
        logic [3:0] prev_pulse = '0;
        logic [3:0] prev_busy = '0;
        logic       prev_clr = 1'b0;
        logic [3:0] dk;
        logic [3:0] acc;
        int         exp_cnt = 0;
        int         nc;
        for (int i = 0; i < 4; i++) begin
            exp_deliv[i] = 0;
            dpc[i] = 0;
        end
        forever begin
            @(negedge clk1);
            if (reset) begin
                chk("rst_busy", busy, 0);
                chk("rst_drop_pulse", drop_pulse, 0);
                chk("rst_drop_cnt", drop_cnt, 0);
                exp_cnt = 0;
                prev_pulse = '0;
                prev_busy = '0;
                prev_clr = 1'b0;
                for (int i = 0; i < 4; i++) exp_deliv[i] = deliv[i];
            end else begin
`ifdef PULSE_SYNC_PENDING_EN
                dk = drop_pulse;
`else
                dk = prev_pulse & prev_busy;
                chk("drop_pulse", drop_pulse, dk);
`endif
                acc = prev_pulse & ~prev_busy;
                if (acc != 4'd0) chk("busy_rise", busy & acc, acc);
                nc = exp_cnt + pc(dk);
                if (nc > 7) nc = 7;
                exp_cnt = prev_clr ? 0 : nc;
                chk("drop_cnt", drop_cnt, exp_cnt);
                drops_total += pc(dk);
                for (int i = 0; i < 4; i++) begin
                    if (dk[i]) dpc[i]++;
                    if (prev_pulse[i] && !dk[i]) exp_deliv[i]++;
                end
                prev_pulse = pulse_in;
                prev_busy = busy;
                prev_clr = drop_clr;
            end
        end
    end

    // Clock-2 monitor: each delivered pulse is single-cycle and never exceeds accepted events.
    initial begin
        logic [3:0] prev_po = '0;
        for (int i = 0; i < 4; i++) deliv[i] = 0;
        forever begin
            @(negedge clk2);
            if (!reset) begin
                for (int i = 0; i < 4; i++) begin
                    if (pulse_out[i]) begin
                        deliv[i]++;
                        chk("po_single", prev_po[i], 0);
                        chk("po_excess", deliv[i] <= exp_deliv[i], 1);
                    end
                end
            end
            prev_po = reset ? 4'd0 : pulse_out;
        end
    end

    initial begin
        int n;
        int d0;
        int dp0;
        int ev;
        int dr0;
        logic [31:0] r;
        realtime ratios[4];
        ratios[0] = 35.0;
        ratios[1] = 10.0;
        ratios[2] = 5.0;
        ratios[3] = 5.0 / 3.0;

        #0.5 reset = 1'b1;
        repeat (4) @(posedge clk1);
        #1 reset = 1'b0;
        @(negedge clk1);
        chk("init_busy", busy, 0);
        chk("init_drop_pulse", drop_pulse, 0);
        chk("init_drop_cnt", drop_cnt, 0);
        chk("init_pulse_out", pulse_out, 0);

        // single event with forward latency measurement
        tick();
        pulse_in = 4'b0001;
        d0 = deliv[0];
        @(posedge clk1);
        #1 pulse_in = 4'b0000;
        chk("single_busy_rise", busy[0], 1);
        n = 0;
        while (n < 8) begin
            @(posedge clk2);
            n++;
            @(negedge clk2);
            if (pulse_out[0]) break;
        end
        chk("single_latency_3to4", (n >= 3 && n <= 4), 1);
        wait_idle();
        chk("single_delivered", deliv[0] - d0, 1);
        chk("single_drop_cnt", drop_cnt, 0);
        chk("single_busy_fall", busy, 0);

        // pulse_in[1] held for three cycles
        d0 = deliv[1];
        dp0 = dpc[1];
        tick(); pulse_in = 4'b0010;
        tick();
        tick();
        tick(); pulse_in = 4'b0000;
        wait_idle();
        chk("b2b_delivered", deliv[1] - d0, PEND ? 2 : 1);
        chk("b2b_drop_pulses", dpc[1] - dp0, PEND ? 1 : 2);
        chk("b2b_drop_cnt", drop_cnt, PEND ? 1 : 2);

        // all channels twice in a row
        tick(); drop_clr = 1'b1;
        tick(); drop_clr = 1'b0;
        d0 = sum_deliv();
        pulse_in = 4'b1111;
        tick();
        tick(); pulse_in = 4'b0000;
        wait_idle();
        chk("simul_delivered", sum_deliv() - d0, PEND ? 8 : 4);
        chk("simul_drop_cnt", drop_cnt, PEND ? 0 : 4);

        // saturation, then clear coincident with a drop
        tick(); drop_clr = 1'b1;
        tick(); drop_clr = 1'b0;
        pulse_in = 4'b1100;
        repeat (5) tick();
        pulse_in = 4'b0100;
        drop_clr = 1'b1;
        @(negedge clk1);
        chk("sat_hold7", drop_cnt, 7);
        tick(); pulse_in = 4'b0000; drop_clr = 1'b0;
        @(negedge clk1);
        chk("clr_to_zero", drop_cnt, 0);
        chk("clr_drop_pulse_fires", drop_pulse[2], 1);
        wait_idle();

        // reset while a handshake is in flight
        d0 = deliv[0];
        tick(); pulse_in = 4'b0001;
        tick(); pulse_in = 4'b0000;
        reset = 1'b1;
        repeat (2) @(negedge clk1);
        chk("midrst_busy", busy, 0);
        chk("midrst_pulse_out", pulse_out, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        @(posedge clk1);
        #1 reset = 1'b0;
        wait_idle();
        chk("midrst_no_ghost", deliv[0] - d0, 0);
        tick(); pulse_in = 4'b0001;
        tick(); pulse_in = 4'b0000;
        wait_idle();
        chk("midrst_new_event", deliv[0] - d0, 1);

        // clock ratio sweep with random event spacing
        for (int k = 0; k < 4; k++) begin
            h2 = ratios[k];
            repeat (20) @(posedge clk2);
            tick(); drop_clr = 1'b1;
            tick(); drop_clr = 1'b0;
            d0 = sum_deliv();
            dr0 = drops_total;
            ev = 0;
            for (int c = 0; c < 80; c++) begin
                r = $urandom;
                pulse_in = r[3:0] & r[7:4];
                ev += pc(pulse_in);
                tick();
            end
            pulse_in = 4'b0000;
            wait_idle();
            chk("sweep_conservation", (sum_deliv() - d0) + (drops_total - dr0), ev);
            chk("sweep_drop_cnt", drop_cnt, (drops_total - dr0) > 7 ? 7 : (drops_total - dr0));
            for (int i = 0; i < 4; i++) chk("sweep_channel_balance", deliv[i], exp_deliv[i]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
